// File: rtl/xcorr_peak_finder.sv
// Serial argmax over the lag axis of six cross-correlation vectors.
// One comparator per pair walks the captured snapshot one lag index per clock.
module xcorr_peak_finder #(
   parameter int NUM_BITS_XCORR    = 32,
   parameter int MAX_SAMPLES_DELAY = 9,
   parameter int NUM_XCORRS        = 6,
   parameter int NUM_BITS_LAG      = 5
) (
   input  logic                                                      clk,
   input  logic                                                      rst,
   input  logic                                                      validIn,
   input  logic [(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_XCORR-1:0]         xCorrIn0,
   input  logic [(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_XCORR-1:0]         xCorrIn1,
   input  logic [(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_XCORR-1:0]         xCorrIn2,
   input  logic [(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_XCORR-1:0]         xCorrIn3,
   input  logic [(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_XCORR-1:0]         xCorrIn4,
   input  logic [(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_XCORR-1:0]         xCorrIn5,
   output logic                                                      validOut,
   output logic [NUM_BITS_LAG-1:0]                                   lag0,
   output logic [NUM_BITS_LAG-1:0]                                   lag1,
   output logic [NUM_BITS_LAG-1:0]                                   lag2,
   output logic [NUM_BITS_LAG-1:0]                                   lag3,
   output logic [NUM_BITS_LAG-1:0]                                   lag4,
   output logic [NUM_BITS_LAG-1:0]                                   lag5,
   output logic [NUM_BITS_XCORR-1:0]                                 peak0,
   output logic [NUM_BITS_XCORR-1:0]                                 peak1,
   output logic [NUM_BITS_XCORR-1:0]                                 peak2,
   output logic [NUM_BITS_XCORR-1:0]                                 peak3,
   output logic [NUM_BITS_XCORR-1:0]                                 peak4,
   output logic [NUM_BITS_XCORR-1:0]                                 peak5,
   output logic                                                      busy,
   output logic                                                      overrun
);

   localparam int NUM_LAGS = 2*MAX_SAMPLES_DELAY+1;
   localparam int VEC_W    = NUM_LAGS*NUM_BITS_XCORR;
   localparam int IDX_W    = $clog2(NUM_LAGS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAGS-1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                           state;
   logic [IDX_W-1:0]                 k;
   logic [VEC_W-1:0]                 in_vec   [NUM_XCORRS];
   logic signed [NUM_BITS_XCORR-1:0] snap     [NUM_XCORRS][NUM_LAGS];
   logic signed [NUM_BITS_XCORR-1:0] run_max  [NUM_XCORRS];
   logic [IDX_W-1:0]                 run_idx  [NUM_XCORRS];
   logic signed [NUM_BITS_XCORR-1:0] cand     [NUM_XCORRS];
   logic signed [NUM_BITS_XCORR-1:0] next_max [NUM_XCORRS];
   logic [IDX_W-1:0]                 next_idx [NUM_XCORRS];
   logic [NUM_BITS_LAG-1:0]          next_lag [NUM_XCORRS];
   logic [NUM_BITS_LAG-1:0]          lag_r    [NUM_XCORRS];
   logic [NUM_BITS_XCORR-1:0]        peak_r   [NUM_XCORRS];

   assign in_vec[0] = xCorrIn0;
   assign in_vec[1] = xCorrIn1;
   assign in_vec[2] = xCorrIn2;
   assign in_vec[3] = xCorrIn3;
   assign in_vec[4] = xCorrIn4;
   assign in_vec[5] = xCorrIn5;

   // Index 0 always loads; afterwards only a strictly larger value wins, so ties keep the most negative lag.
   always_comb begin
      for (int p = 0; p < NUM_XCORRS; p++) begin
         cand[p]     = snap[p][k];
         next_max[p] = run_max[p];
         next_idx[p] = run_idx[p];
         if ((k == '0) || (cand[p] > run_max[p])) begin
            next_max[p] = cand[p];
            next_idx[p] = k;
         end
         next_lag[p] = NUM_BITS_LAG'(next_idx[p]) - NUM_BITS_LAG'(MAX_SAMPLES_DELAY);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         k        <= '0;
         validOut <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         for (int p = 0; p < NUM_XCORRS; p++) begin
            run_max[p] <= '0;
            run_idx[p] <= '0;
            lag_r[p]   <= '0;
            peak_r[p]  <= '0;
            for (int i = 0; i < NUM_LAGS; i++) begin
               snap[p][i] <= '0;
            end
         end
      end else begin
         validOut <= 1'b0;
         if (state == IDLE) begin
            if (validIn) begin
               for (int p = 0; p < NUM_XCORRS; p++) begin
                  for (int i = 0; i < NUM_LAGS; i++) begin
                     snap[p][i] <= in_vec[p][i*NUM_BITS_XCORR +: NUM_BITS_XCORR];
                  end
               end
               k     <= '0;
               busy  <= 1'b1;
               state <= SCAN;
            end
         end else begin
            // A pulse arriving mid-scan is dropped; only the sticky flag records it.
            if (validIn) begin
               overrun <= 1'b1;
            end
            for (int p = 0; p < NUM_XCORRS; p++) begin
               run_max[p] <= next_max[p];
               run_idx[p] <= next_idx[p];
            end
            if (k == LAST_IDX) begin
               for (int p = 0; p < NUM_XCORRS; p++) begin
                  lag_r[p]  <= next_lag[p];
                  peak_r[p] <= next_max[p];
               end
               validOut <= 1'b1;
               busy     <= 1'b0;
               k        <= '0;
               state    <= IDLE;
            end else begin
               k <= k + IDX_W'(1);
            end
         end
      end
   end

   assign lag0  = lag_r[0];
   assign lag1  = lag_r[1];
   assign lag2  = lag_r[2];
   assign lag3  = lag_r[3];
   assign lag4  = lag_r[4];
   assign lag5  = lag_r[5];
   assign peak0 = peak_r[0];
   assign peak1 = peak_r[1];
   assign peak2 = peak_r[2];
   assign peak3 = peak_r[3];
   assign peak4 = peak_r[4];
   assign peak5 = peak_r[5];

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Bench for xcorr_peak_finder: table of vectors with expected lags/peaks feeding
// a scoreboard queue that a negedge monitor drains on every validOut pulse.
module tb_xcorr_peak_finder;

   localparam int W   = 32;
   localparam int MSD = 9;
   localparam int NL  = 2*MSD+1;
   localparam int VW  = NL*W;
   localparam int LW  = 5;
   localparam int LAT = NL;

   typedef struct packed {
      logic [5:0][VW-1:0] vec;
      logic [5:0][LW-1:0] lag;
      logic [5:0][W-1:0]  peak;
   } case_t;

   typedef struct packed {
      logic [5:0][LW-1:0] lag;
      logic [5:0][W-1:0]  peak;
      int                 start;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               valid_in;
   logic [5:0][VW-1:0] xin;
   logic               valid_out;
   logic               busy;
   logic               overrun;
   logic [5:0][LW-1:0] lag_o;
   logic [5:0][W-1:0]  peak_o;

   case_t cases [3];
   exp_t  sb [$];
   exp_t  mon_e;
   int    cyc = 0;
   int    passed = 0;
   int    total = 0;
   logic  last_vo = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   xcorr_peak_finder dut (
      .clk(clk), .rst(rst), .validIn(valid_in),
      .xCorrIn0(xin[0]), .xCorrIn1(xin[1]), .xCorrIn2(xin[2]),
      .xCorrIn3(xin[3]), .xCorrIn4(xin[4]), .xCorrIn5(xin[5]),
      .validOut(valid_out),
      .lag0(lag_o[0]), .lag1(lag_o[1]), .lag2(lag_o[2]),
      .lag3(lag_o[3]), .lag4(lag_o[4]), .lag5(lag_o[5]),
      .peak0(peak_o[0]), .peak1(peak_o[1]), .peak2(peak_o[2]),
      .peak3(peak_o[3]), .peak4(peak_o[4]), .peak5(peak_o[5]),
      .busy(busy), .overrun(overrun)
   );

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [VW-1:0] fill_vec(input logic [W-1:0] val);
      logic [VW-1:0] r;
      for (int i = 0; i < NL; i++) r[i*W +: W] = val;
      return r;
   endfunction

   function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int idx, input logic [W-1:0] val);
      v[idx*W +: W] = val;
      return v;
   endfunction

   // Must be called at a falling edge; leaves validIn low one cycle later.
   task automatic apply_stimulus(input case_t c, input bit accept);
      exp_t e;
      xin      = c.vec;
      valid_in = 1'b1;
      if (accept) begin
         e.lag   = c.lag;
         e.peak  = c.peak;
         e.start = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output("scoreboard drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_output({tag, " validOut"}, 64'(valid_out), 64'd0);
      check_output({tag, " busy"}, 64'(busy), 64'd0);
      for (int p = 0; p < 6; p++) begin
         check_output($sformatf("%s lag%0d", tag, p), 64'(lag_o[p]), 64'd0);
         check_output($sformatf("%s peak%0d", tag, p), 64'(peak_o[p]), 64'd0);
      end
   endtask

   always @(negedge clk) begin
      if (last_vo) check_output("validOut one cycle", 64'(valid_out), 64'd0);
      last_vo = valid_out;
      if (valid_out) begin
         check_output("result expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check_output("latency", 64'(cyc - mon_e.start), 64'(LAT));
            check_output("busy at validOut", 64'(busy), 64'd0);
            for (int p = 0; p < 6; p++) begin
               check_output($sformatf("lag%0d", p), 64'(lag_o[p]), 64'(mon_e.lag[p]));
               check_output($sformatf("peak%0d", p), 64'(peak_o[p]), 64'(mon_e.peak[p]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int n;

      // Single peak at lag +3 on pair0, others peak at index 0.
      cases[0].vec[0]  = put(fill_vec(32'(-100)), 12, 32'd5000);
      cases[0].lag[0]  = LW'(3);
      cases[0].peak[0] = 32'd5000;
      for (int p = 1; p < 6; p++) begin
         cases[0].vec[p]  = put(fill_vec(32'(-100)), 0, 32'd50);
         cases[0].lag[p]  = LW'(-9);
         cases[0].peak[p] = 32'd50;
      end
      // Ties, all-equal, all-negative and extreme values.
      cases[1].vec[0]  = fill_vec(32'd42);
      cases[1].lag[0]  = LW'(-9);
      cases[1].peak[0] = 32'd42;
      cases[1].vec[1]  = fill_vec(32'd0);
      cases[1].lag[1]  = LW'(-9);
      cases[1].peak[1] = 32'd0;
      cases[1].vec[2]  = put(put(fill_vec(32'd10), 4, 32'd700), 15, 32'd700);
      cases[1].lag[2]  = LW'(-5);
      cases[1].peak[2] = 32'd700;
      cases[1].vec[3]  = put(fill_vec(32'h8000_0000), 18, 32'hFFFF_FFFF);
      cases[1].lag[3]  = LW'(9);
      cases[1].peak[3] = 32'hFFFF_FFFF;
      cases[1].vec[4]  = put(fill_vec(32'd0), 9, 32'h7FFF_FFFF);
      cases[1].lag[4]  = LW'(0);
      cases[1].peak[4] = 32'h7FFF_FFFF;
      cases[1].vec[5]  = put(put(fill_vec(32'(-7)), 17, 32'd3), 18, 32'd3);
      cases[1].lag[5]  = LW'(8);
      cases[1].peak[5] = 32'd3;
      // Distinct peak position per pair.
      for (int p = 0; p < 6; p++) begin
         cases[2].vec[p]  = put(fill_vec(32'(-p-1)), p*3, 32'(1000+p));
         cases[2].lag[p]  = LW'(p*3-9);
         cases[2].peak[p] = 32'(1000+p);
      end

      rst      = 1'b1;
      valid_in = 1'b0;
      xin      = '0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      check_output("reset overrun", 64'(overrun), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         apply_stimulus(cases[i], 1'b1);
         check_output("busy after capture", 64'(busy), 64'd1);
         wait_drain(LAT + 10);
      end

      // Back-to-back: next pulse lands in the validOut cycle.
      apply_stimulus(cases[1], 1'b1);
      n = 0;
      while (!valid_out && n < LAT + 10) begin
         @(negedge clk);
         n++;
      end
      check_output("b2b first validOut seen", 64'(valid_out), 64'd1);
      apply_stimulus(cases[2], 1'b1);
      repeat (5) @(negedge clk);
      check_output("hold lag2 during scan", 64'(lag_o[2]), 64'(cases[1].lag[2]));
      check_output("hold peak2 during scan", 64'(peak_o[2]), 64'(cases[1].peak[2]));
      wait_drain(LAT + 10);
      check_output("b2b overrun", 64'(overrun), 64'd0);

      // Reset in the middle of a scan abandons the result.
      apply_stimulus(cases[0], 1'b1);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero_outputs("mid-scan reset");
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 6) @(negedge clk);
      check_output("idle after reset", 64'(busy), 64'd0);
      apply_stimulus(cases[2], 1'b1);
      wait_drain(LAT + 10);

      // Overrun: second pulse is ignored, later input changes are invisible.
      apply_stimulus(cases[0], 1'b1);
      repeat (4) @(negedge clk);
      apply_stimulus(cases[2], 1'b0);
      check_output("overrun set", 64'(overrun), 64'd1);
      xin = cases[1].vec;
      wait_drain(LAT + 10);
      repeat (LAT + 6) @(negedge clk);
      check_output("overrun sticky", 64'(overrun), 64'd1);
      check_output("overrun result lag0", 64'(lag_o[0]), 64'(cases[0].lag[0]));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
